// File: rtl/ps2_move_sequencer.sv
// Turns PS/2 arrow-key scan codes into bounded, wall-checked player moves and
// sequences the erase/redraw handshake before committing the new position.
module ps2_move_sequencer #(
    parameter logic [7:0] START_X = 8'd4,
    parameter logic [6:0] START_Y = 7'd4,
    parameter int         STEP    = 4,
    parameter logic [7:0] X_MAX   = 8'd156,
    parameter logic [6:0] Y_MAX   = 7'd116,
    parameter logic [7:0] GOAL_X  = 8'd152,
    parameter logic [6:0] GOAL_Y  = 7'd112
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic [7:0] iData,
    input  logic       iDataEn,
    input  logic       iWall,
    input  logic       iDone,
    output logic [7:0] oProbeX,
    output logic [6:0] oProbeY,
    output logic       oGo,
    output logic [3:0] oDir,
    output logic [7:0] oX,
    output logic [6:0] oY,
    output logic       oBusy,
    output logic       oHit,
    output logic       oWon,
    output logic [1:0] oDbgParse,
    output logic [1:0] oDbgMove
);

    localparam logic [1:0] P_IDLE   = 2'd0;
    localparam logic [1:0] P_EXT    = 2'd1;
    localparam logic [1:0] P_BRK    = 2'd2;
    localparam logic [1:0] P_EXTBRK = 2'd3;

    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_PROBE = 2'd1;
    localparam logic [1:0] M_CHECK = 2'd2;
    localparam logic [1:0] M_DRAW  = 2'd3;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    localparam logic signed [8:0] STEP9 = 9'(STEP);

    logic [1:0] parse_q, parse_d;
    logic       pend_valid_q, pend_valid_d;
    logic [3:0] pend_dir_q, pend_dir_d;
    logic [1:0] move_q, move_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [7:0] probe_x_q, probe_x_d;
    logic [6:0] probe_y_q, probe_y_d;
    logic [3:0] dir_q, dir_d;
    logic       go_q, go_d;
    logic       hit_q, hit_d;
    logic       won_q, won_d;

    logic       post;
    logic [3:0] post_dir;
    logic       consume;
    logic signed [8:0] cand_x, cand_y;
    logic       out_of_bounds;

    // Scan-code parser; break sequences swallow exactly one following byte.
    always_comb begin
        parse_d  = parse_q;
        post     = 1'b0;
        post_dir = 4'b0000;
        if (iDataEn) begin
            case (parse_q)
                P_IDLE: begin
                    if (iData == 8'hE0)      parse_d = P_EXT;
                    else if (iData == 8'hF0) parse_d = P_BRK;
                    else                     parse_d = P_IDLE;
                end
                P_EXT: begin
                    parse_d = P_IDLE;
                    case (iData)
                        8'h75: begin post = 1'b1; post_dir = DIR_UP;    end
                        8'h72: begin post = 1'b1; post_dir = DIR_DOWN;  end
                        8'h6B: begin post = 1'b1; post_dir = DIR_LEFT;  end
                        8'h74: begin post = 1'b1; post_dir = DIR_RIGHT; end
                        8'hF0: parse_d = P_EXTBRK;
                        default: parse_d = P_IDLE;
                    endcase
                end
                default: parse_d = P_IDLE;
            endcase
        end
    end

    always_comb begin
        cand_x = $signed({1'b0, x_q});
        cand_y = $signed({2'b00, y_q});
        case (pend_dir_q)
            DIR_UP:    cand_y = cand_y - STEP9;
            DIR_DOWN:  cand_y = cand_y + STEP9;
            DIR_LEFT:  cand_x = cand_x - STEP9;
            DIR_RIGHT: cand_x = cand_x + STEP9;
            default: ;
        endcase
        out_of_bounds = (cand_x < 9'sd0) || (cand_y < 9'sd0) ||
                        (cand_x > $signed({1'b0, X_MAX})) ||
                        (cand_y > $signed({2'b00, Y_MAX}));
    end

    // The probe registers double as the latched move target.
    always_comb begin
        move_d    = move_q;
        x_d       = x_q;
        y_d       = y_q;
        probe_x_d = probe_x_q;
        probe_y_d = probe_y_q;
        dir_d     = dir_q;
        go_d      = 1'b0;
        hit_d     = 1'b0;
        won_d     = won_q;
        consume   = 1'b0;
        case (move_q)
            M_IDLE: begin
                if (pend_valid_q) begin
                    consume = 1'b1;
                    if (!won_q) begin
                        if (out_of_bounds) begin
                            hit_d = 1'b1;
                        end else begin
                            dir_d     = pend_dir_q;
                            probe_x_d = cand_x[7:0];
                            probe_y_d = cand_y[6:0];
                            move_d    = M_PROBE;
                        end
                    end
                end
            end
            M_PROBE: move_d = M_CHECK;
            M_CHECK: begin
                if (iWall) begin
                    hit_d  = 1'b1;
                    dir_d  = 4'b0000;
                    move_d = M_IDLE;
                end else begin
                    go_d   = 1'b1;
                    move_d = M_DRAW;
                end
            end
            default: begin
                // A done coincident with the start pulse is stale and ignored.
                if (iDone && !go_q) begin
                    x_d    = probe_x_q;
                    y_d    = probe_y_q;
                    dir_d  = 4'b0000;
                    move_d = M_IDLE;
                    if (probe_x_q == GOAL_X && probe_y_q == GOAL_Y) won_d = 1'b1;
                end
            end
        endcase
    end

    // A post wins over a same-cycle consume so the newest request survives.
    always_comb begin
        pend_valid_d = post | (pend_valid_q & ~consume);
        pend_dir_d   = post ? post_dir : pend_dir_q;
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            parse_q      <= P_IDLE;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= 4'b0000;
            move_q       <= M_IDLE;
            x_q          <= START_X;
            y_q          <= START_Y;
            probe_x_q    <= START_X;
            probe_y_q    <= START_Y;
            dir_q        <= 4'b0000;
            go_q         <= 1'b0;
            hit_q        <= 1'b0;
            won_q        <= 1'b0;
        end else begin
            parse_q      <= parse_d;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
            move_q       <= move_d;
            x_q          <= x_d;
            y_q          <= y_d;
            probe_x_q    <= probe_x_d;
            probe_y_q    <= probe_y_d;
            dir_q        <= dir_d;
            go_q         <= go_d;
            hit_q        <= hit_d;
            won_q        <= won_d;
        end
    end

    assign oProbeX   = probe_x_q;
    assign oProbeY   = probe_y_q;
    assign oGo       = go_q;
    assign oDir      = dir_q;
    assign oX        = x_q;
    assign oY        = y_q;
    assign oBusy     = (move_q != M_IDLE);
    assign oHit      = hit_q;
    assign oWon      = won_q;
    assign oDbgParse = parse_q;
    assign oDbgMove  = move_q;

endmodule

// File: tb/tb_ps2_move_sequencer.sv
// Directed bench for ps2_move_sequencer: cycle-exact timing of accepted and
// rejected moves, parser break handling, request overwrite and win/reset.
module tb_ps2_move_sequencer;

    logic       iClock = 1'b0;
    logic       iReset = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iDataEn = 1'b0;
    logic       iWall = 1'b0;
    logic       iDone = 1'b0;
    logic [7:0] oProbeX;
    logic [6:0] oProbeY;
    logic       oGo;
    logic [3:0] oDir;
    logic [7:0] oX;
    logic [6:0] oY;
    logic       oBusy;
    logic       oHit;
    logic       oWon;
    logic [1:0] oDbgParse;
    logic [1:0] oDbgMove;

    int checks = 0;
    int errors = 0;

    ps2_move_sequencer dut (
        .iClock(iClock), .iReset(iReset), .iData(iData), .iDataEn(iDataEn),
        .iWall(iWall), .iDone(iDone), .oProbeX(oProbeX), .oProbeY(oProbeY),
        .oGo(oGo), .oDir(oDir), .oX(oX), .oY(oY), .oBusy(oBusy), .oHit(oHit),
        .oWon(oWon), .oDbgParse(oDbgParse), .oDbgMove(oDbgMove)
    );

    always #5 iClock = ~iClock;

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic do_reset();
        iReset = 1'b1; iData = 8'h00; iDataEn = 1'b0; iWall = 1'b0; iDone = 1'b0;
        tick();
        tick();
        iReset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        iData = b;
        iDataEn = 1'b1;
        tick();
        iDataEn = 1'b0;
        iData = 8'h00;
    endtask

    task automatic wait_go(output logic found);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (oGo === 1'b1) found = 1'b1;
            else tick();
        end
    endtask

    // Watch a window of cycles for any start pulse, hit pulse or busy flag.
    task automatic quiet_window(input int n, output logic saw_go, output logic saw_hit, output logic saw_busy);
        saw_go = 1'b0; saw_hit = 1'b0; saw_busy = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (oGo !== 1'b0) saw_go = 1'b1;
            if (oHit !== 1'b0) saw_hit = 1'b1;
            if (oBusy !== 1'b0) saw_busy = 1'b1;
        end
    endtask

    // Full extended move with an immediately answering draw datapath.
    task automatic run_move(input logic [7:0] code, output logic found);
        send_byte(8'hE0);
        send_byte(code);
        wait_go(found);
        if (found) begin
            tick();
            iDone = 1'b1;
            tick();
            iDone = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (oX !== 8'd4) begin errors++; $display("FAIL reset_x: got %0d expected 4", oX); end
        checks++; if (oY !== 7'd4) begin errors++; $display("FAIL reset_y: got %0d expected 4", oY); end
        checks++; if (oDir !== 4'b0000) begin errors++; $display("FAIL reset_dir: got %b expected 0000", oDir); end
        checks++; if ({oGo, oBusy, oHit, oWon} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {oGo, oBusy, oHit, oWon}); end
        checks++; if ({oProbeX, oProbeY} !== {8'd4, 7'd4}) begin errors++; $display("FAIL reset_probe: got %0d,%0d expected 4,4", oProbeX, oProbeY); end
        checks++; if ({oDbgParse, oDbgMove} !== 4'b0000) begin errors++; $display("FAIL reset_states: got %b expected 0000", {oDbgParse, oDbgMove}); end
    endtask

    task automatic test_accept_right();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h74);
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL right_busy_n1: got %b expected 0", oBusy); end
        tick();
        checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL right_busy_n2: got %b expected 1", oBusy); end
        checks++; if ({oProbeX, oProbeY} !== {8'd8, 7'd4}) begin errors++; $display("FAIL right_probe: got %0d,%0d expected 8,4", oProbeX, oProbeY); end
        tick();
        checks++; if (oGo !== 1'b0) begin errors++; $display("FAIL right_go_n3: got %b expected 0", oGo); end
        tick();
        checks++; if (oGo !== 1'b1) begin errors++; $display("FAIL right_go_n4: got %b expected 1", oGo); end
        checks++; if (oDir !== 4'b0001) begin errors++; $display("FAIL right_dir: got %b expected 0001", oDir); end
        iDone = 1'b1;
        tick();
        checks++; if ({oGo, oBusy} !== 2'b01) begin errors++; $display("FAIL right_go_cycle_done: got go,busy=%b expected 01", {oGo, oBusy}); end
        checks++; if (oX !== 8'd4) begin errors++; $display("FAIL right_early_commit: got %0d expected 4", oX); end
        tick();
        iDone = 1'b0;
        checks++; if ({oX, oY} !== {8'd8, 7'd4}) begin errors++; $display("FAIL right_commit: got %0d,%0d expected 8,4", oX, oY); end
        checks++; if ({oBusy, oHit, oDir} !== 6'b000000) begin errors++; $display("FAIL right_after: got busy,hit,dir=%b expected 000000", {oBusy, oHit, oDir}); end
    endtask

    task automatic test_up_bounds();
        logic found, sg, sh, sb;
        do_reset();
        run_move(8'h75, found);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL up_to_zero_go: got %b expected 1", found); end
        checks++; if (oY !== 7'd0) begin errors++; $display("FAIL up_to_zero_y: got %0d expected 0", oY); end
        send_byte(8'hE0);
        send_byte(8'h75);
        checks++; if (oHit !== 1'b0) begin errors++; $display("FAIL bound_hit_n1: got %b expected 0", oHit); end
        tick();
        checks++; if ({oHit, oBusy} !== 2'b10) begin errors++; $display("FAIL bound_hit_n2: got hit,busy=%b expected 10", {oHit, oBusy}); end
        tick();
        checks++; if (oHit !== 1'b0) begin errors++; $display("FAIL bound_hit_width: got %b expected 0", oHit); end
        quiet_window(6, sg, sh, sb);
        checks++; if ({sg, sh, sb} !== 3'b000) begin errors++; $display("FAIL bound_quiet: got go,hit,busy=%b expected 000", {sg, sh, sb}); end
        checks++; if (oY !== 7'd0) begin errors++; $display("FAIL bound_y: got %0d expected 0", oY); end
    endtask

    task automatic test_wall();
        logic sg, sh, sb;
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h72);
        tick();
        checks++; if ({oProbeX, oProbeY} !== {8'd4, 7'd8}) begin errors++; $display("FAIL wall_probe: got %0d,%0d expected 4,8", oProbeX, oProbeY); end
        tick();
        iWall = 1'b1;
        tick();
        iWall = 1'b0;
        checks++; if ({oHit, oBusy, oGo} !== 3'b100) begin errors++; $display("FAIL wall_n4: got hit,busy,go=%b expected 100", {oHit, oBusy, oGo}); end
        checks++; if ({oX, oY, oDir} !== {8'd4, 7'd4, 4'b0000}) begin errors++; $display("FAIL wall_pos: got %0d,%0d dir %b expected 4,4 dir 0000", oX, oY, oDir); end
        quiet_window(6, sg, sh, sb);
        checks++; if ({sg, sh, sb} !== 3'b000) begin errors++; $display("FAIL wall_quiet: got go,hit,busy=%b expected 000", {sg, sh, sb}); end
    endtask

    task automatic test_parser_breaks();
        logic sg, sh, sb;
        do_reset();
        send_byte(8'hE0);
        checks++; if (oDbgParse !== 2'd1) begin errors++; $display("FAIL parse_ext: got %0d expected 1", oDbgParse); end
        send_byte(8'hF0);
        checks++; if (oDbgParse !== 2'd3) begin errors++; $display("FAIL parse_extbrk: got %0d expected 3", oDbgParse); end
        send_byte(8'h74);
        send_byte(8'h74);
        checks++; if (oDbgParse !== 2'd0) begin errors++; $display("FAIL parse_plain: got %0d expected 0", oDbgParse); end
        send_byte(8'hF0);
        checks++; if (oDbgParse !== 2'd2) begin errors++; $display("FAIL parse_brk: got %0d expected 2", oDbgParse); end
        send_byte(8'h6B);
        checks++; if (oDbgParse !== 2'd0) begin errors++; $display("FAIL parse_end: got %0d expected 0", oDbgParse); end
        quiet_window(8, sg, sh, sb);
        checks++; if ({sg, sh, sb} !== 3'b000) begin errors++; $display("FAIL parse_quiet: got go,hit,busy=%b expected 000", {sg, sh, sb}); end
        checks++; if ({oX, oY} !== {8'd4, 7'd4}) begin errors++; $display("FAIL parse_pos: got %0d,%0d expected 4,4", oX, oY); end
    endtask

    task automatic test_back_to_back();
        logic found, sg, sh, sb;
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h74);
        wait_go(found);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL b2b_first_go: got %b expected 1", found); end
        send_byte(8'hE0);
        send_byte(8'h6B);
        send_byte(8'hE0);
        send_byte(8'h72);
        checks++; if ({oBusy, oX} !== {1'b1, 8'd4}) begin errors++; $display("FAIL b2b_wait: got busy %b x %0d expected 1 4", oBusy, oX); end
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        checks++; if ({oX, oY} !== {8'd8, 7'd4}) begin errors++; $display("FAIL b2b_commit1: got %0d,%0d expected 8,4", oX, oY); end
        wait_go(found);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL b2b_second_go: got %b expected 1", found); end
        checks++; if (oDir !== 4'b0100) begin errors++; $display("FAIL b2b_second_dir: got %b expected 0100", oDir); end
        tick();
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        checks++; if ({oX, oY, oBusy} !== {8'd8, 7'd8, 1'b0}) begin errors++; $display("FAIL b2b_commit2: got %0d,%0d busy %b expected 8,8 busy 0", oX, oY, oBusy); end
        quiet_window(8, sg, sh, sb);
        checks++; if ({sg, sh, sb} !== 3'b000) begin errors++; $display("FAIL b2b_quiet: got go,hit,busy=%b expected 000", {sg, sh, sb}); end
    endtask

    task automatic test_reset_mid_draw();
        logic found, sg, sh, sb;
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h74);
        wait_go(found);
        tick();
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        checks++; if ({oBusy, oGo, oDir, oX} !== {1'b0, 1'b0, 4'b0000, 8'd4}) begin errors++; $display("FAIL midreset: got busy %b go %b dir %b x %0d expected 0 0 0000 4", oBusy, oGo, oDir, oX); end
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        quiet_window(6, sg, sh, sb);
        checks++; if ({sg, sh, sb, oX} !== {3'b000, 8'd4}) begin errors++; $display("FAIL midreset_quiet: got go,hit,busy=%b x %0d expected 000 4", {sg, sh, sb}, oX); end
    endtask

    task automatic test_win();
        logic found, all_found, sg, sh, sb;
        do_reset();
        all_found = 1'b1;
        for (int i = 0; i < 36; i++) begin run_move(8'h74, found); all_found &= found; end
        for (int i = 0; i < 27; i++) begin run_move(8'h72, found); all_found &= found; end
        checks++; if (all_found !== 1'b1) begin errors++; $display("FAIL win_walk_go: got %b expected 1", all_found); end
        checks++; if ({oX, oY, oWon} !== {8'd148, 7'd112, 1'b0}) begin errors++; $display("FAIL win_pre: got %0d,%0d won %b expected 148,112 won 0", oX, oY, oWon); end
        run_move(8'h74, found);
        checks++; if ({found, oX, oWon} !== {1'b1, 8'd152, 1'b1}) begin errors++; $display("FAIL win_set: got go %b x %0d won %b expected 1 152 1", found, oX, oWon); end
        send_byte(8'hE0);
        send_byte(8'h6B);
        quiet_window(8, sg, sh, sb);
        checks++; if ({sg, sh, sb, oX} !== {3'b000, 8'd152}) begin errors++; $display("FAIL win_locked: got go,hit,busy=%b x %0d expected 000 152", {sg, sh, sb}, oX); end
        do_reset();
        checks++; if ({oWon, oX, oY} !== {1'b0, 8'd4, 7'd4}) begin errors++; $display("FAIL win_reset: got won %b %0d,%0d expected 0 4,4", oWon, oX, oY); end
    endtask

    initial begin
        test_reset();
        test_accept_right();
        test_up_bounds();
        test_wall();
        test_parser_breaks();
        test_back_to_back();
        test_reset_mid_draw();
        test_win();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_move_sequencer.md
# ps2_move_sequencer

Controller between the PS/2 receiver and the box-drawing datapath. It parses raw PS/2 scan-code bytes into arrow-key move requests and checks each move against the playfield bounds and a wall lookup. It then launches the erase/redraw of the player box with a start/done handshake, and commits the new position. It replaces the direct scan-code-to-direction wiring and is the single owner of the player position and the win flag.

## Interface

**Parameters**
- START_X, 8'd4: player x after reset.
- START_Y, 7'd4: player y after reset.
- STEP, 4: pixels moved per accepted key.
- X_MAX, 8'd156: largest legal x (160-wide screen, 4-pixel box).
- Y_MAX, 7'd116: largest legal y (120-high screen).
- GOAL_X, 8'd152: x of the goal cell.
- GOAL_Y, 7'd112: y of the goal cell.

**Ports**
- iClock, in, 1: system clock (CLOCK_50).
- iReset, in, 1: synchronous, active-high reset.
- iData, in, 8: PS/2 received byte.
- iDataEn, in, 1: one-cycle strobe marking iData valid.
- iWall, in, 1: wall flag for (oProbeX, oProbeY). Valid exactly one cycle after the probe is driven.
- iDone, in, 1: draw datapath finished the erase/redraw (one-cycle pulse).
- oProbeX, out, 8: candidate x for the wall lookup.
- oProbeY, out, 7: candidate y for the wall lookup.
- oGo, out, 1: one-cycle start pulse to the draw datapath.
- oDir, out, 4: one-hot direction {up, down, left, right}. Held stable from oGo until iDone.
- oX, out, 8: committed player x.
- oY, out, 7: committed player y.
- oBusy, out, 1: high while the move FSM is not in M_IDLE.
- oHit, out, 1: one-cycle pulse when a move is rejected (wall or bounds).
- oWon, out, 1: sticky; set when the committed position equals the goal.

## Operation

**Scan-code parser.** States P_IDLE, P_EXT, P_BRK, P_EXTBRK. It advances only on cycles where iDataEn is high.
- In P_IDLE:
  - E0 goes to P_EXT.
  - F0 goes to P_BRK.
  - Any other byte stays in P_IDLE.
- In P_EXT:
  - 75, 72, 6B, 74 post an up, down, left, right request and return to P_IDLE.
  - F0 goes to P_EXTBRK.
  - Any other byte returns to P_IDLE.
- In P_BRK or P_EXTBRK, the next byte is discarded and the parser returns to P_IDLE.
- Non-extended 75/72/6B/74 (keypad codes) are ignored.
- Typematic repeats of a make code each post a new request.

**Pending buffer.** One entry (valid bit plus one-hot direction).
- A new request overwrites the pending one (latest wins).
- The buffer is cleared when the move FSM consumes it.
- A post and a consume in the same cycle leave the new request pending.

**Move FSM.** States M_IDLE, M_PROBE, M_CHECK, M_DRAW.
- **M_IDLE:** If pending is valid and oWon is 0, consume it and compute the target position = oX/oY ± STEP (9-bit signed compare).
  - If the target is < 0 or > X_MAX/Y_MAX, pulse oHit and stay in M_IDLE.
  - Otherwise latch oDir and the target, then go to M_PROBE.
  - If oWon is 1, pending requests are consumed and dropped.
- **M_PROBE:** Drive oProbeX/oProbeY = target, then go to M_CHECK.
- **M_CHECK:** Sample iWall.
  - If iWall is 1, pulse oHit, clear oDir, and go to M_IDLE.
  - If iWall is 0, go to M_DRAW.
- **M_DRAW:** oGo is high in the first cycle only. Wait for iDone; an iDone in the oGo cycle is ignored. On iDone, oX/oY take the target, oDir clears, the FSM goes to M_IDLE, and oWon is set if the target equals (GOAL_X, GOAL_Y).

oProbeX/oProbeY hold their last value outside M_PROBE.

## Timing

- **Reset values:** parser in P_IDLE, pending cleared, FSM in M_IDLE, oX=START_X, oY=START_Y, oDir=0, oGo=0, oBusy=0, oHit=0, oWon=0, oProbeX=START_X, oProbeY=START_Y.
- **Accepted move.** Let n be the cycle in which the code byte is strobed after E0.
  - Pending is valid at n+1.
  - M_PROBE is at n+2 (probe outputs valid).
  - M_CHECK is at n+3 (iWall sampled).
  - oGo is high at n+4.
  - If iDone is at cycle d > n+4, oX/oY/oWon update and oBusy falls at d+1.
- **Rejected moves:**
  - Wall: oHit pulses at n+4 and oBusy falls at n+4.
  - Bounds: oHit pulses at n+2 and oBusy stays 0.
- **Reset mid-operation:** iReset high in any cycle forces all reset values on the next edge, including during M_DRAW. oGo is never reissued for an aborted move.
- **iDone outside M_DRAW** is ignored.

## Test plan

- Reset, then bytes E0,74 → oGo at n+4 with oDir=4'b0001. After iDone, oX=8, oY=4, oHit=0.
- From (4,4), bytes E0,75 (up, target y=0): the move is accepted and oY=0 after iDone. Then E0,75 again (target y=-4) → oHit pulse, no oGo, oY stays 0.
- E0,72 with iWall=1 in the cycle after the probe → oHit at n+4, no oGo, position unchanged, oBusy=0 at n+4.
- E0,F0,74 (break), then plain 74, then F0,6B → no request, no oGo, parser ends in P_IDLE.
- During M_DRAW, send E0,6B then E0,72 before iDone → after commit, exactly one further move (down) executes.
- Preload the position one step left of the goal and send a right move → oWon=1 after iDone. A further E0,6B produces no oGo. Assert iReset → oWon=0, oX=4, oY=4.
